mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter between the IFU fetch port and the LSU data port, sharing a single memory/bus slave port.
- Accepts at most one outstanding transaction and latches it into internal registers before presenting it to the slave.
- Returns the slave response to the owning master only; the grant is held until that response handshake completes.
- Sits between the fetch/LSU stages and the SRAM/bus bridge; all ports use valid/ready handshakes.

---
 rtl/mem_bus_arbiter_pkg.sv | 11 +
 rtl/mem_bus_arbiter_arb_grant.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 119 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory bus arbiter: FSM states and master IDs.
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;
endpackage

// File: rtl/mem_bus_arbiter_arb_grant.sv
// Grant selection between IFU and LSU. Define ARB_RR_EN for round-robin on ties;
// otherwise LSU has fixed priority over IFU.
module arb_grant
  import mem_bus_arbiter_pkg::*;
(
  input  logic       ifu_req_i,
  input  logic       lsu_req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o      // bit0 = IFU, bit1 = LSU
);
`ifdef ARB_RR_EN
  always_comb begin
    grant_o = 2'b00;
    if (ifu_req_i && lsu_req_i)
      grant_o = (last_grant_i == MST_IFU) ? 2'b10 : 2'b01;
    else if (lsu_req_i)
      grant_o = 2'b10;
    else if (ifu_req_i)
      grant_o = 2'b01;
  end
`else
  // Pointer is still tracked by the top but has no effect under fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    grant_o = 2'b00;
    if (lsu_req_i)
      grant_o = 2'b10;
    else if (ifu_req_i)
      grant_o = 2'b01;
  end
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (IFU, LSU) to one-slave bus arbiter, one outstanding transaction.
// Grant policy selected by ARB_RR_EN (round-robin) vs default fixed LSU priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                wen;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wmask;
  } mem_req_t;

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  mem_req_t   req_q, req_d;
  logic [1:0] grant;

  arb_grant u_grant (
    .ifu_req_i    (ifu_req_valid),
    .lsu_req_i    (lsu_req_valid),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= MST_IFU;
      last_q  <= MST_IFU;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    req_d          = req_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        ifu_req_ready = grant[0];
        lsu_req_ready = grant[1];
        if (grant[1] && lsu_req_valid) begin
          req_d   = '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
          owner_d = MST_LSU;
          state_d = ARB_REQ;
        end else if (grant[0] && ifu_req_valid) begin
          // Fetches are always reads: no write data or strobes reach the slave.
          req_d   = '{addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
          owner_d = MST_IFU;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        mem_resp_ready = (owner_q == MST_LSU) ? lsu_resp_ready : ifu_resp_ready;
        ifu_resp_valid = (owner_q == MST_IFU) && mem_resp_valid;
        lsu_resp_valid = (owner_q == MST_LSU) && mem_resp_valid;
        if (mem_resp_valid && mem_resp_ready) begin
          last_d  = owner_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign mem_addr  = req_q.addr;
  assign mem_wen   = req_q.wen;
  assign mem_wdata = req_q.wdata;
  assign mem_wmask = req_q.wmask;
  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of the grant/routing rules.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 0;
  logic [31:0] ifu_addr = 0, ifu_rdata;
  logic        lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0, lsu_resp_valid, lsu_resp_ready = 0;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
  logic [3:0]  lsu_wmask = 0;
  logic        mem_req_valid, mem_req_ready = 0, mem_wen, mem_resp_valid = 0, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wmask;

  int n_cmp = 0;
  int n_err = 0;
  bit m_last = 1'b0;   // model's last-granted master: 1 = LSU
`ifdef ARB_RR_EN
  bit rr_mode = 1'b1;
`else
  bit rr_mode = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction. w (1 = LSU) is the model's winner; the slave side is
  // driven here with the given request stall, response delay and owner backpressure.
  task automatic do_txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                        input bit lw, input logic [31:0] lwd, input logic [3:0] lwm,
                        input int rq_dly, input int rs_dly, input int bp, input logic [31:0] rd);
    bit          w;
    logic [68:0] exp_f;
    bit          done;
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lwm;
    #1;
    if (iv && lv) w = rr_mode ? ~m_last : 1'b1;
    else          w = lv;
    chk("ifu_req_ready", ifu_req_ready, !w);
    chk("lsu_req_ready", lsu_req_ready, w);
    exp_f = w ? {la, lw, lwd, lwm} : {ia, 1'b0, 32'h0, 4'h0};
    tick();
    // Both masters keep requesting while busy; neither may be accepted.
    ifu_req_valid = 1; lsu_req_valid = 1; mem_resp_valid = 1; mem_rdata = rd;
    #1;
    for (int i = 0; i <= rq_dly; i++) begin
      chk("mem_req_valid", mem_req_valid, 1'b1);
      chk("mem_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, exp_f);
      chk("busy_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
      chk("no_resp_in_req", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      if (i == rq_dly) mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      #1;
    end
    done = 0;
    for (int i = 0; i <= rs_dly + bp + 1 && !done; i++) begin
      mem_resp_valid = (i >= rs_dly);
      ifu_resp_ready = w ? 1'b1 : (i >= bp);
      lsu_resp_ready = w ? (i >= bp) : 1'b1;
      #1;
      chk("owner_resp_valid", w ? lsu_resp_valid : ifu_resp_valid, mem_resp_valid);
      chk("other_resp_valid", w ? ifu_resp_valid : lsu_resp_valid, 1'b0);
      chk("mem_resp_ready", mem_resp_ready, (i >= bp));
      chk("busy_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
      if (mem_resp_valid)
        chk("owner_rdata", w ? lsu_rdata : ifu_rdata, rd);
      if (i >= rs_dly && i >= bp) begin
        done = 1;
        ifu_req_valid = 0; lsu_req_valid = 0;
      end
      tick();
    end
    chk("txn_completed", done, 1'b1);
    mem_resp_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
    #1;
    chk("idle_outputs", {mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 3'b000);
    m_last = w;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    #1;
    chk("rst_valids", {mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 3'b000);
    chk("rst_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, 69'h0);
    chk("rst_state", dut.state_q, ARB_IDLE);
    rst = 0;
    tick();
    chk("idle_no_req_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);

    // Fetch alone: response visible two cycles after the handshake
    do_txn(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0413);

    // LSU write with 3 cycles of slave request stall
    do_txn(0, 1, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 3, 0, 0, 32'h1234_5678);

    // Ties
    for (int t = 0; t < 4; t++)
      do_txn(1, 1, 32'h100 + t, 32'h200 + t, t[0], 32'hA5A5_0000 + t, 4'hF, 0, 1, 0, 32'h55 + t);

    // Response backpressure with a pending LSU request
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    #1;
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    lsu_req_valid = 1; lsu_addr = 32'h9000_0000; lsu_wen = 0;
    mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D; ifu_resp_ready = 0; lsu_resp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_mem_resp_ready", mem_resp_ready, 1'b0);
      chk("bp_ifu_resp_valid", ifu_resp_valid, 1'b1);
      chk("bp_lsu_blocked", lsu_req_ready, 1'b0);
      chk("bp_state", dut.state_q, ARB_RESP);
      tick();
    end
    ifu_resp_ready = 1;
    #1;
    chk("bp_release", mem_resp_ready, 1'b1);
    tick();
    mem_resp_valid = 0; ifu_resp_ready = 0;
    m_last = 1'b0;
    #1;
    chk("pending_lsu_granted", lsu_req_ready, 1'b1);
    do_txn(0, 1, 32'h0, 32'h9000_0000, 0, 32'h0, 4'h0, 1, 2, 1, 32'h0BAD_CAFE);

    // Reset in RESP: nothing forwarded, back to IDLE
    ifu_req_valid = 1; ifu_addr = 32'h8000_0080;
    #1;
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    rst = 1; mem_resp_valid = 1; ifu_resp_ready = 1;
    #1;
    chk("rst_mid_valids", {mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_resp_ready}, 4'b0000);
    chk("rst_mid_state", dut.state_q, ARB_IDLE);
    tick();
    rst = 0;
    tick();
    chk("post_rst_no_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    mem_resp_valid = 0; ifu_resp_ready = 0;
    m_last = 1'b0;
    do_txn(1, 0, 32'h8000_00C0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0013);

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      int k;
      k = $urandom_range(1, 3);
      do_txn(k[0], k[1], $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
